// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Data-memory side of the load/store interface. Accepts one access per
//   req_valid/req_ready handshake. For stores it shifts the data and byte
//   enables to the addressed lanes. For loads it issues a word read on the
//   SRAM port, waits a variable number of cycles for mem_rvalid, and then
//   returns the extracted, sign- or zero-extended result. stall stays high
//   while an access is in flight.
//
// Parameters
//   ADDR_W       byte-address width (memory word address is ADDR_W-2 bits)
//   TIMEOUT_CYC  cycles spent waiting for mem_rvalid before a bus error
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   req_valid/req_ready                request handshake
//   req_we, req_addr, req_wdata,
//   req_wbyte_en, req_rsize,
//   req_unsigned                       access controls, sampled on accept
//   resp_valid, resp_rdata, bus_err,
//   misalign                           one-cycle completion signals
//   stall                              pipeline hold request
//   mem_req, mem_we, mem_addr, mem_be,
//   mem_wdata, mem_rdata, mem_rvalid   word-wide SRAM port
//
// Build option
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses are
//                          answered with a misalign pulse and never reach
//                          memory; otherwise the offset is masked to the
//                          natural alignment and the access proceeds.
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wbyte_en,
    input  logic [1:0]        req_rsize,
    input  logic              req_unsigned,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              bus_err,
    output logic              misalign,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WADR_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_CMD  = 2'd2,
        RD_WAIT = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              misalign_q, misalign_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [WADR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        rsize_q, rsize_d;
    logic              uns_q, uns_d;

    logic              accept_c;
    logic              trap_c;
    logic              timeout_c;
    logic              is_word_c;
    logic              is_half_c;
    logic [1:0]        off_raw_c;
    logic [1:0]        eff_off_c;
    logic [31:0]       rd_shift_c;
    logic [31:0]       load_ext_c;

    assign accept_c  = req_valid & req_ready_q;
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Access size decode: stores are sized by their enable pattern, loads by rsize.
    always_comb begin
        off_raw_c = req_addr[1:0];
        if (req_we) begin
            is_word_c = (req_wbyte_en == 4'b1111);
            is_half_c = (req_wbyte_en == 4'b0011);
        end else begin
            is_word_c = req_rsize[1];
            is_half_c = (req_rsize == 2'b01);
        end
        // Lane offset forced to the natural alignment of the access size.
        if (is_word_c) begin
            eff_off_c = 2'b00;
        end else if (is_half_c) begin
            eff_off_c = {off_raw_c[1], 1'b0};
        end else begin
            eff_off_c = off_raw_c;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap_c = (is_half_c & off_raw_c[0]) | (is_word_c & (off_raw_c != 2'b00));
`else
    assign trap_c = 1'b0;
`endif

    // Load data extraction from the returned word.
    always_comb begin
        rd_shift_c = mem_rdata >> {off_q, 3'b000};
        case (rsize_q)
            2'b00:   load_ext_c = {{24{rd_shift_c[7]  & ~uns_q}}, rd_shift_c[7:0]};
            2'b01:   load_ext_c = {{16{rd_shift_c[15] & ~uns_q}}, rd_shift_c[15:0]};
            default: load_ext_c = rd_shift_c;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c && !trap_c) begin
                    state_d = req_we ? WR : RD_CMD;
                end
            end
            WR:      state_d = IDLE;
            RD_CMD:  state_d = RD_WAIT;
            RD_WAIT: begin
                if (mem_rvalid || timeout_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; strobes default low, bus fields hold.
    always_comb begin
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        bus_err_d    = 1'b0;
        misalign_d   = 1'b0;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        rsize_d      = rsize_q;
        uns_d        = uns_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    off_d   = eff_off_c;
                    rsize_d = req_rsize;
                    uns_d   = req_unsigned;
                    if (trap_c) begin
                        misalign_d   = 1'b1;
                        resp_valid_d = 1'b1;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = req_addr[ADDR_W-1:2];
                        if (req_we) begin
                            // Store completes in the same cycle its command is on the bus.
                            mem_we_d     = 1'b1;
                            mem_be_d     = 4'(req_wbyte_en << eff_off_c);
                            mem_wdata_d  = req_wdata << {eff_off_c, 3'b000};
                            resp_valid_d = 1'b1;
                        end else begin
                            mem_be_d    = 4'b1111;
                            mem_wdata_d = 32'h0;
                        end
                    end
                end
            end
            RD_CMD: begin
                cnt_d = '0;
            end
            RD_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Data takes priority over a coincident timeout.
                if (mem_rvalid) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_ext_c;
                end else if (timeout_c) begin
                    resp_valid_d = 1'b1;
                    bus_err_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and access context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            bus_err_q    <= 1'b0;
            misalign_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'h0;
            mem_wdata_q  <= 32'h0;
            cnt_q        <= '0;
            off_q        <= 2'b00;
            rsize_q      <= 2'b00;
            uns_q        <= 1'b0;
        end else begin
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            bus_err_q    <= bus_err_d;
            misalign_q   <= misalign_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            rsize_q      <= rsize_d;
            uns_q        <= uns_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign bus_err    = bus_err_q;
    assign misalign   = misalign_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

    // Stall covers both a blocked request and any access still in flight.
    assign stall = (req_valid & ~req_ready_q) | (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned TIMEOUT_CYC = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wbyte_en;
    logic [1:0]        req_rsize;
    logic              req_unsigned;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              bus_err;
    logic              misalign;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;

    dmem_responder #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wbyte_en (req_wbyte_en),
        .req_rsize    (req_rsize),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .bus_err      (bus_err),
        .misalign     (misalign),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        bus_err;
        logic        misalign;
    } resp_t;

    resp_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Independent reference for load extraction.
    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        int          sh;
        sh = 8 * int'(off);
        b  = word[sh +: 8];
        h  = off[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Scoreboard monitor: every response must match the oldest expectation.
    always @(posedge clk) begin : mon
        resp_t e;
        #1;
        if (rst_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_bus_err", bus_err, e.bus_err);
                check("resp_misalign", misalign, e.misalign);
            end
        end
    end

    // Present one request and return at the sample point of the cycle after accept.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [1:0] rsize, input logic uns);
        @(negedge clk);
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_wbyte_en = be;
        req_rsize    = rsize;
        req_unsigned = uns;
        req_valid    = 1'b1;
        check("ready_before_req", req_ready, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
        exp_q.push_back(resp_t'{rdata: 32'h0, bus_err: 1'b0, misalign: 1'b0});
        issue(1'b1, addr, wdata, be, 2'b00, 1'b0);
        check({tag, "_mem_req"}, mem_req, 32'd1);
        check({tag, "_mem_we"}, mem_we, 32'd1);
        check({tag, "_mem_addr"}, 32'(mem_addr), addr >> 2);
        check({tag, "_mem_be"}, 32'(mem_be), 32'(exp_be));
        check({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
        check({tag, "_resp_valid"}, resp_valid, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_mem_req_drop"}, mem_req, 32'd0);
        check({tag, "_ready_after"}, req_ready, 32'd1);
    endtask

    // dly = cycle (after the command cycle) in which mem_rvalid is driven; 0 = never.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] rsize,
                           input logic uns, input logic [31:0] word, input int dly,
                           input logic [31:0] exp_data);
        int lat;
        int exp_lat;
        lat = 0;
        if (dly == 0) begin
            exp_q.push_back(resp_t'{rdata: 32'h0, bus_err: 1'b1, misalign: 1'b0});
            exp_lat = TIMEOUT_CYC + 1;
        end else begin
            exp_q.push_back(resp_t'{rdata: exp_data, bus_err: 1'b0, misalign: 1'b0});
            exp_lat = dly + 1;
        end
        issue(1'b0, addr, 32'h0, 4'h0, rsize, uns);
        check({tag, "_mem_req"}, mem_req, 32'd1);
        check({tag, "_mem_we"}, mem_we, 32'd0);
        check({tag, "_mem_be"}, 32'(mem_be), 32'hF);
        check({tag, "_mem_addr"}, 32'(mem_addr), addr >> 2);
        check({tag, "_stall_cmd"}, stall, 32'd1);
        for (int i = 1; i <= int'(TIMEOUT_CYC) + 8; i++) begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
            if (resp_valid) begin
                lat = i;
                break;
            end
            if (stall !== 1'b1) check({tag, "_stall_wait"}, stall, 32'd1);
            if (i == dly) begin
                mem_rdata  = word;
                mem_rvalid = 1'b1;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_ready_resp"}, req_ready, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  rs;
        logic [1:0]  off;
        logic        uns;
        logic [31:0] word;
        int          dly;

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_wdata    = 32'h0;
        req_wbyte_en = 4'h0;
        req_rsize    = 2'b00;
        req_unsigned = 1'b0;
        mem_rdata    = 32'h0;
        mem_rvalid   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 32'd1);
        check("rst_resp_valid", resp_valid, 32'd0);
        check("rst_bus_err", bus_err, 32'd0);
        check("rst_misalign", misalign, 32'd0);
        check("rst_mem_req", mem_req, 32'd0);
        check("rst_mem_we", mem_we, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_stall", stall, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stores: lane shifting of data and enables.
        do_store("sw", 32'h100, 32'hDEADBEEF, 4'b1111, 4'b1111, 32'hDEADBEEF);
        do_store("sb3", 32'h103, 32'h000000A5, 4'b0001, 4'b1000, 32'hA5000000);
        do_store("sh2", 32'h102, 32'h00001234, 4'b0011, 4'b1100, 32'h12340000);
        do_store("sb1", 32'h201, 32'h0000005A, 4'b0001, 4'b0010, 32'h00005A00);

        // Loads: sign/zero extension, latency, timeout and the coincidence case.
        do_load("lb", 32'h101, 2'b00, 1'b0, 32'h0000F000, 3, 32'hFFFFFFF0);
        do_load("lbu", 32'h101, 2'b00, 1'b1, 32'h0000F000, 3, 32'h000000F0);
        do_load("lh_timeout", 32'h102, 2'b01, 1'b0, 32'h0, 0, 32'h0);
        do_load("lhu", 32'h102, 2'b01, 1'b1, 32'h8001_0000, 1, 32'h00008001);
        do_load("lw_edge", 32'h104, 2'b10, 1'b1, 32'hCAFEF00D, TIMEOUT_CYC, 32'hCAFEF00D);
        do_load("lw_late", 32'h108, 2'b11, 1'b0, 32'h80000001, TIMEOUT_CYC - 1, 32'h80000001);

        // Randomised naturally aligned loads against the reference model.
        for (int n = 0; n < 8; n++) begin
            rs   = 2'($urandom_range(0, 2));
            off  = 2'($urandom_range(0, 3));
            if (rs == 2'b01) off[0] = 1'b0;
            if (rs == 2'b10) off = 2'b00;
            uns  = 1'($urandom_range(0, 1));
            word = $urandom;
            dly  = int'($urandom_range(1, 4));
            do_load("rnd", 32'h400 + 32'(n * 4) + 32'(off), rs, uns, word, dly,
                    ref_load(word, off, rs, uns));
        end

        // Misaligned word / half accesses.
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_q.push_back(resp_t'{rdata: 32'h0, bus_err: 1'b0, misalign: 1'b1});
        issue(1'b0, 32'h102, 32'h0, 4'h0, 2'b10, 1'b0);
        check("mis_no_mem_req", mem_req, 32'd0);
        check("mis_resp_valid", resp_valid, 32'd1);
        check("mis_flag", misalign, 32'd1);
        check("mis_ready", req_ready, 32'd1);
        @(posedge clk);
        #1;
        check("mis_flag_drop", misalign, 32'd0);
        check("mis_no_mem_req2", mem_req, 32'd0);
`else
        do_load("lw_mis", 32'h102, 2'b10, 1'b0, 32'h89ABCDEF, 2, 32'h89ABCDEF);
        check("lw_mis_flag", misalign, 32'd0);
        do_load("lh_mis", 32'h103, 2'b01, 1'b0, 32'h8000_1234, 1, 32'hFFFF8000);
        do_store("sw_mis", 32'h102, 32'h11223344, 4'b1111, 4'b1111, 32'h11223344);
`endif

        // Stray mem_rvalid while idle is ignored.
        @(negedge clk);
        mem_rdata  = 32'h12345678;
        mem_rvalid = 1'b1;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        check("stray_idle_resp", resp_valid, 32'd0);

        // Reset in the middle of a read abandons it silently.
        issue(1'b0, 32'h180, 32'h0, 4'h0, 2'b10, 1'b0);
        @(posedge clk);
        #1;
        check("mid_rst_stall", stall, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", req_ready, 32'd1);
        check("mid_rst_resp", resp_valid, 32'd0);
        check("mid_rst_mem_req", mem_req, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_rdata  = 32'hFFFFFFFF;
        mem_rvalid = 1'b1;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        check("post_rst_resp0", resp_valid, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_resp1", resp_valid, 32'd0);
        check("post_rst_ready", req_ready, 32'd1);
        check("post_rst_stall", stall, 32'd0);

        // Normal operation resumes.
        do_store("sw_after", 32'h3FC, 32'h0BADF00D, 4'b1111, 4'b1111, 32'h0BADF00D);
        do_load("lb_after", 32'h3FE, 2'b00, 1'b0, 32'h00800000, 2, 32'hFFFFFF80);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
